// File: rtl/gray_arb_pkg.sv
// Shared definitions for the Gray-decode arbiter: FSM state encoding and the
// ceil(log2) helper used to size requester IDs.
package gray_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/gray_to_bin_comb.sv
// Purely combinational Gray-to-binary converter: each binary bit is the XOR of
// all Gray bits at or above its position.
module gray_to_bin_comb #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] binary
);

  // NOTE: every variable written in always_comb gets a value before it is
  // read or conditionally updated, so no latch can be inferred.
  always_comb begin
    logic [WIDTH-1:0] acc;
    acc            = '0;
    acc[WIDTH-1]   = gray[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      acc[i] = acc[i+1] ^ gray[i];
    end
    binary = acc;
  end

endmodule

// File: rtl/gray_decode_arbiter.sv
// Round-robin arbiter sharing one Gray-to-binary decoder among NREQ requesters,
// with a single registered output slot tagged by the winning requester ID.
module gray_decode_arbiter
  import gray_arb_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4,
  parameter int IDW   = clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_gray,
  output logic [NREQ-1:0]       req_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_binary,
  output logic [IDW-1:0]        out_id
);

  arb_state_e       state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0] out_binary_q, out_binary_d;
  logic [IDW-1:0]   out_id_q, out_id_d;

  logic             load_en;
  logic             grant_found;
  logic [IDW-1:0]   grant_idx;
  logic             handshake;
  logic [WIDTH-1:0] win_gray;
  logic [WIDTH-1:0] win_binary;

  // The slot is free when empty or when the held word leaves this cycle.
  assign load_en = (state_q == IDLE) || (out_ready && (state_q == HOLD));

  // First valid requester scanning upward from rr_ptr, wrapping mod NREQ.
  always_comb begin
    logic [IDW-1:0] idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = rr_ptr_q + IDW'(k);
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = idx;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (!rst && load_en && grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  assign handshake = |(req_valid & req_ready);
  assign win_gray  = req_gray[grant_idx*WIDTH +: WIDTH];

  gray_to_bin_comb #(.WIDTH(WIDTH)) u_decode (
    .gray   (win_gray),
    .binary (win_binary)
  );

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    out_binary_d = out_binary_q;
    out_id_d     = out_id_q;
    if (handshake) begin
      state_d      = HOLD;
      rr_ptr_d     = grant_idx + IDW'(1);
      out_binary_d = win_binary;
      out_id_d     = grant_idx;
    end else if ((state_q == HOLD) && out_ready) begin
      state_d = IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      out_binary_q <= '0;
      out_id_q     <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      out_binary_q <= out_binary_d;
      out_id_q     <= out_id_d;
    end
  end

  assign out_valid  = (state_q == HOLD);
  assign out_binary = out_binary_q;
  assign out_id     = out_id_q;

endmodule

// File: tb/tb_gray_decode_arbiter.sv
// Directed self-checking bench for gray_decode_arbiter (WIDTH=4, NREQ=4):
// reset, single grants, round-robin wrap, stall, drain and reset mid-hold.
module tb_gray_decode_arbiter;

  localparam int WIDTH = 4;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_gray;
  logic [NREQ-1:0]       req_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_binary;
  logic [IDW-1:0]        out_id;

  int checks   = 0;
  int failures = 0;

  // Hand-computed decodes of the Gray words loaded into each requester below.
  logic [WIDTH-1:0] rr_gray [NREQ] = '{4'b0101, 4'b0110, 4'b1101, 4'b1000};
  logic [WIDTH-1:0] rr_bin  [NREQ] = '{4'b0110, 4'b0100, 4'b1001, 4'b1111};
  int               rr_order [5]   = '{0, 1, 2, 3, 0};

  gray_decode_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_gray   (req_gray),
    .req_ready  (req_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_binary (out_binary),
    .out_id     (out_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [WIDTH-1:0] b,
                           input logic [IDW-1:0] id);
    check({tag, "_valid"},  32'(out_valid),  32'(v));
    check({tag, "_binary"}, 32'(out_binary), 32'(b));
    check({tag, "_id"},     32'(out_id),     32'(id));
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 4'b1111;
    req_gray  = '0;
    out_ready = 1'b1;

    // Reset: requests pending but nothing may be granted.
    settle();
    check("rst_ready_0", 32'(req_ready), 32'h0);
    tick();
    check_out("rst_1", 1'b0, 4'b0000, 2'd0);
    check("rst_ready_1", 32'(req_ready), 32'h0);
    tick();
    check_out("rst_2", 1'b0, 4'b0000, 2'd0);

    // Only requester 2 valid with Gray 1101.
    rst       = 1'b0;
    req_valid = 4'b0100;
    req_gray[2*WIDTH +: WIDTH] = 4'b1101;
    settle();
    check("single_ready", 32'(req_ready), 32'b0100);
    tick();
    check_out("single_out", 1'b1, 4'b1001, 2'd2);

    // Requester 3 with Gray 1000 (rr_ptr is 3 now), then drain with no valids.
    req_valid = 4'b1000;
    req_gray[3*WIDTH +: WIDTH] = 4'b1000;
    settle();
    check("b2b_ready", 32'(req_ready), 32'b1000);
    tick();
    check_out("b2b_out", 1'b1, 4'b1111, 2'd3);
    req_valid = 4'b0000;
    settle();
    check("drain_ready", 32'(req_ready), 32'h0);
    tick();
    check_out("drain_out", 1'b0, 4'b1111, 2'd3);

    // All four valid, out_ready held high: grants 0,1,2,3,0.
    for (int i = 0; i < NREQ; i++) req_gray[i*WIDTH +: WIDTH] = rr_gray[i];
    req_valid = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      settle();
      check($sformatf("rr_ready_%0d", n), 32'(req_ready), 32'(1) << rr_order[n]);
      tick();
      check_out($sformatf("rr_out_%0d", n), 1'b1, rr_bin[rr_order[n]], IDW'(rr_order[n]));
    end

    // Load requester 1 (Gray 0110), then stall for 3 cycles under full pressure.
    req_valid = 4'b0010;
    settle();
    check("stall_load_ready", 32'(req_ready), 32'b0010);
    tick();
    check_out("stall_load_out", 1'b1, 4'b0100, 2'd1);
    out_ready = 1'b0;
    req_valid = 4'b1111;
    for (int n = 0; n < 3; n++) begin
      settle();
      check($sformatf("stall_ready_%0d", n), 32'(req_ready), 32'h0);
      tick();
      check_out($sformatf("stall_out_%0d", n), 1'b1, 4'b0100, 2'd1);
    end

    // Reset while holding: word dropped, pointer back to 0.
    rst = 1'b1;
    settle();
    check("hold_rst_ready", 32'(req_ready), 32'h0);
    tick();
    check_out("hold_rst_out", 1'b0, 4'b0000, 2'd0);
    rst       = 1'b0;
    out_ready = 1'b1;
    settle();
    check("post_rst_ready", 32'(req_ready), 32'b0001);
    tick();
    check_out("post_rst_out", 1'b1, 4'b0110, 2'd0);

    // Single requester active: granted on every free cycle.
    req_valid = 4'b0100;
    for (int n = 0; n < 2; n++) begin
      settle();
      check($sformatf("solo_ready_%0d", n), 32'(req_ready), 32'b0100);
      tick();
      check_out($sformatf("solo_out_%0d", n), 1'b1, 4'b1001, 2'd2);
    end

    req_valid = 4'b0000;
    tick();
    check_out("final_idle", 1'b0, 4'b1001, 2'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
